dmem_sized: RTL

Parametrised byte-addressed data memory for the pipelined core's MEM stage. It replaces the fixed 64-bit, 1 KiB, two-cycle data memory with the following additions:

- configurable depth, data width and read latency;
- RISC-V style access sizes with sign or zero extension;
- alignment and range checking with an error response;
- a post-reset clearing sweep instead of a single-cycle reset of the whole array.

Every accepted request returns exactly one in-order response.

---
 rtl/dmem_sized.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/dmem_sized.sv
// Byte-addressed data memory for the MEM stage: sized/extended loads and stores,
// alignment/range error responses, a zeroing sweep after reset, fixed-latency responses.
module dmem_sized #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int DEPTH_BYTES = 1024,
  parameter int RD_LAT      = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic              o_rsp_err,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_dbg_state
);

  localparam int NB     = DATA_W / 8;
  localparam int NWORDS = DEPTH_BYTES / NB;
  localparam int BA_W   = $clog2(DEPTH_BYTES);
  localparam int LOG_NB = $clog2(NB);
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             init_we;

  // Handshake: a request transfers on a rising edge where i_req_valid && o_req_ready;
  // the response is a single-cycle o_rsp_valid pulse RD_LAT cycles later, no backpressure.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    o_req_ready = 1'b0;
    init_we     = 1'b0;
    case (state_q)
      S_INIT: begin
        init_we = 1'b1;
        if (cnt_q == CNT_W'(NWORDS - 1)) state_d = S_READY;
        else                             cnt_d   = cnt_q + 1'b1;
      end
      S_READY: o_req_ready = 1'b1;
    endcase
  end

  assign o_dbg_state = state_q;

  // Request decode and error checks
  logic            accept;
  logic [3:0]      nb4;
  logic [2:0]      amask;
  logic [ADDR_W:0] end_addr;
  logic            err_size, err_align, err_range, req_err;
  logic [BA_W-1:0] idx;

  assign accept    = i_req_valid && o_req_ready;
  assign nb4       = 4'd1 << i_req_size;
  assign amask     = 3'(nb4 - 4'd1);
  // One extra bit so addresses near the top of the address space cannot wrap into range.
  assign end_addr  = {1'b0, i_req_addr} + {{(ADDR_W-3){1'b0}}, nb4};
  assign err_size  = (i_req_size == 2'd3) && (DATA_W == 32);
  assign err_align = |(i_req_addr[2:0] & amask);
  assign err_range = end_addr > (ADDR_W+1)'(DEPTH_BYTES);
  assign req_err   = err_size || err_align || err_range;
  assign idx       = i_req_addr[BA_W-1:0];

  logic [7:0] mem [DEPTH_BYTES];

  always_ff @(posedge i_clk) begin
    if (init_we) begin
      for (int k = 0; k < NB; k++) mem[{cnt_q, LOG_NB'(k)}] <= 8'h00;
    end else if (accept && i_req_we && !req_err) begin
      for (int k = 0; k < NB; k++)
        if (k < int'(nb4)) mem[idx + BA_W'(k)] <= i_req_wdata[8*k +: 8];
    end
  end

  // Load path reads the array as it stands before this edge's store commits.
  logic [DATA_W-1:0] raw, ld_data;
  logic              sign_bit, fill;

  always_comb begin
    raw = '0;
    for (int k = 0; k < NB; k++) raw[8*k +: 8] = mem[idx + BA_W'(k)];
    sign_bit = 1'b0;
    for (int k = 0; k < NB; k++)
      if (k == int'(nb4) - 1) sign_bit = raw[8*k + 7];
    fill    = sign_bit & ~i_req_unsigned;
    ld_data = '0;
    for (int k = 0; k < NB; k++)
      ld_data[8*k +: 8] = (k < int'(nb4)) ? raw[8*k +: 8] : {8{fill}};
  end

  logic              v_q [RD_LAT];
  logic              e_q [RD_LAT];
  logic [DATA_W-1:0] d_q [RD_LAT];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        v_q[i] <= 1'b0;
        e_q[i] <= 1'b0;
        d_q[i] <= '0;
      end
    end else begin
      v_q[0] <= accept;
      e_q[0] <= accept && req_err;
      d_q[0] <= (accept && !i_req_we && !req_err) ? ld_data : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        v_q[i] <= v_q[i-1];
        e_q[i] <= e_q[i-1];
        d_q[i] <= d_q[i-1];
      end
    end
  end

  assign o_rsp_valid = v_q[RD_LAT-1];
  assign o_rsp_err   = e_q[RD_LAT-1];
  assign o_rsp_data  = d_q[RD_LAT-1];

endmodule
